// File: rtl/uart_pkg.sv
// Shared UART types, sizes and the parity rule used by both directions.
// No ports: imported by uart_rx_if, uart_rx_fifo and uart_rx.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 14;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BIT_W      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } rx_state_t;

    // Even parity bit is the XOR of the data; odd parity is its inverse.
    function automatic logic parity_bit(
        input logic [DATA_W-1:0] d,
        input logic              odd
    );
        return odd ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Core-bus side of the UART receiver: FIFO read port and sticky error flags.
// master = core (drives rd_en/clr_err), slave = receiver (drives the rest).
interface uart_rx_if;
    import uart_pkg::*;

    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  rx_count;
    logic              rx_empty;
    logic              rx_full;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rx_count, rx_empty, rx_full,
        input  parity_err, frame_err, overrun
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rx_count, rx_empty, rx_full,
        output parity_err, frame_err, overrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; head reads 0 while empty.
// Ports: push/push_data in, pop in, head/count/empty/full/push_ok out.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              push_ok
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises Rx_in, samples frames mid-bit, checks parity/stop, fills FIFO.
// Ports: clk, rst_n, Rx_in, baud_divisor, Rx_en, Two_stop, Odd_parity, bus (uart_rx_if.slave).
module uart_rx
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Rx_in,
    input  logic [DIV_W-1:0] baud_divisor,
    input  logic             Rx_en,
    input  logic             Two_stop,
    input  logic             Odd_parity,
    uart_rx_if.slave         bus
);

    logic              rx_meta;
    logic              rx_s;
    logic              rx_prev;
    rx_state_t         state;
    logic [DIV_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;
    logic              push_q;
    logic              fe_q;
    logic              enabled;
    logic              fall;
    logic              sample;
    logic              push_ok;
    logic              pe_evt;
    logic              ov_evt;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              overrun_q;

    assign enabled = Rx_en && (baud_divisor != '0);
    assign fall    = rx_prev && !rx_s;
    assign sample  = (cnt == (baud_divisor >> 1));

    // Synchroniser resets to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            push_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            fe_q   <= 1'b0;
            if (!enabled) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                if (state == IDLE) begin
                    cnt <= '0;
                end else begin
                    cnt <= (cnt == baud_divisor) ? '0 : cnt + 1'b1;
                end
                unique case (state)
                    IDLE: begin
                        if (fall) state <= START;
                    end
                    START: begin
                        if (sample) begin
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end
                    end
                    DATA: begin
                        if (sample) begin
                            shreg   <= {rx_s, shreg[DATA_W-1:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == BIT_W'(DATA_W - 1)) state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (sample) begin
                            par_bad <= (rx_s != parity_bit(shreg, Odd_parity));
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (sample) begin
                            if (!rx_s) begin
                                fe_q  <= 1'b1;
                                state <= IDLE;
                            end else if (Two_stop) begin
                                state <= STOP2;
                            end else begin
                                push_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    STOP2: begin
                        if (sample) begin
                            if (!rx_s) fe_q <= 1'b1;
                            else push_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // shreg and par_bad hold still until the next frame's data bits,
    // so they are valid while push_q is high.
    uart_rx_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (shreg),
        .pop       (bus.rd_en),
        .head      (bus.rd_data),
        .count     (bus.rx_count),
        .empty     (bus.rx_empty),
        .full      (bus.rx_full),
        .push_ok   (push_ok)
    );

    assign pe_evt = push_q && par_bad && push_ok;
    assign ov_evt = push_q && !push_ok;

    // New error events take priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            parity_err_q <= pe_evt || (parity_err_q && !bus.clr_err);
            frame_err_q  <= fe_q   || (frame_err_q  && !bus.clr_err);
            overrun_q    <= ov_evt || (overrun_q    && !bus.clr_err);
        end
    end

    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a frame-level queue model.
// Drives serial frames bit by bit; checks FIFO view and sticky flags after each.
module tb_uart_rx;
    import uart_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_in = 1'b1;
    logic [DIV_W-1:0] div = 14'd15;
    logic             rx_en = 1'b1;
    logic             two = 1'b0;
    logic             odd = 1'b0;

    uart_rx_if bus();

    uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rx_in        (rx_in),
        .baud_divisor (div),
        .Rx_en        (rx_en),
        .Two_stop     (two),
        .Odd_parity   (odd),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    logic [7:0] q[$];
    bit m_pe, m_fe, m_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.rx_count), q.size());
        chk({tag, ".empty"}, 32'(bus.rx_empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(bus.rx_full), 32'(q.size() == FIFO_DEPTH));
        chk({tag, ".data"}, 32'(bus.rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".perr"}, 32'(bus.parity_err), 32'(m_pe));
        chk({tag, ".ferr"}, 32'(bus.frame_err), 32'(m_fe));
        chk({tag, ".ovr"}, 32'(bus.overrun), 32'(m_ov));
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        chk({tag, ".pop"}, 32'(bus.rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        m_pe = 0; m_fe = 0; m_ov = 0;
    endtask

    // Serial frame: start, 8 data LSB first, parity, 1 or 2 stops.
    // pop/clr land on the cycle the received byte reaches the FIFO.
    // abort_at/rst_at (cycle index, -1 = off) cut the frame short.
    task automatic send_frame(
        input logic [7:0] d,
        input bit bad_par, input bit bad_s1, input bit bad_s2,
        input bit pop_at, input bit clr_at,
        input int abort_at, input int rst_at
    );
        int p, h, nb, evt;
        logic [11:0] fb;
        logic par;
        p = int'(div) + 1;
        h = int'(div) / 2;
        nb = two ? 12 : 11;
        evt = 4 + h + (two ? 11 : 10) * p;
        par = (odd ? ~^d : ^d) ^ bad_par;
        fb = {~bad_s2, ~bad_s1, par, d, 1'b0};
        for (int cyc = 0; cyc < nb * p; cyc++) begin
            @(negedge clk);
            rx_in = (rst_at >= 0 && cyc >= rst_at) ? 1'b1 : fb[cyc / p];
            bus.rd_en = pop_at && (cyc == evt);
            bus.clr_err = clr_at && (cyc == evt);
            if (cyc == abort_at) rx_en = 1'b0;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                q.delete();
                m_pe = 0; m_fe = 0; m_ov = 0;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                check_all("rst_mid");
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        rx_in = 1'b1;
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        rx_en = 1'b1;
        if (abort_at < 0 && rst_at < 0) begin
            if (clr_at) begin
                m_pe = 0; m_fe = 0; m_ov = 0;
            end
            if (pop_at && q.size() > 0) void'(q.pop_front());
            if (bad_s1 || (two && bad_s2)) begin
                m_fe = 1;
            end else if (q.size() < FIFO_DEPTH) begin
                q.push_back(d);
                if (bad_par) m_pe = 1;
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 0, 0, 0, 0, 0, -1, -1);
    endtask

    initial begin
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        m_pe = 0; m_fe = 0; m_ov = 0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'hA5);
        check_all("t1");
        pop_one("t1");

        odd = 1'b1;
        send_frame(8'h3C, 1, 0, 0, 0, 0, -1, -1);
        check_all("t2");
        clr_pulse();
        check_all("t2.clr");
        pop_one("t2");
        odd = 1'b0;

        send_frame(8'h55, 0, 1, 0, 0, 0, -1, -1);
        check_all("t3");
        clr_pulse();

        @(negedge clk);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check_all("t4");

        for (int i = 0; i <= 8; i++) send(8'(i));
        check_all("t5");
        for (int i = 0; i < 8; i++) pop_one("t5");
        check_all("t5.drain");
        clr_pulse();

        two = 1'b1;
        for (int i = 0; i < 7; i++) send(8'(8'h40 + i));
        send(8'h81);
        send_frame(8'h7E, 0, 0, 0, 1, 0, -1, -1);
        check_all("t6.full");
        while (q.size() > 0) pop_one("t6");
        check_all("t6.drain");
        send(8'h33);
        send_frame(8'hC3, 0, 0, 0, 0, 0, -1, 3 * 16);
        check_all("t6.rst");
        send(8'h12);
        check_all("t6.after");
        two = 1'b0;

        send_frame(8'h99, 0, 0, 0, 0, 0, 5 * 16, -1);
        check_all("abort");

        send_frame(8'h5A, 0, 0, 0, 0, 1, -1, -1);
        send_frame(8'hF0, 1, 0, 0, 0, 0, -1, -1);
        send_frame(8'h0F, 0, 0, 0, 0, 1, -1, -1);
        check_all("clr_vs_evt");
        clr_pulse();

        for (int n = 0; n < 40; n++) begin
            div = 14'($urandom_range(7, 31));
            two = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            send_frame(8'($urandom),
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 9) == 0,
                       -1, -1);
            check_all("rnd");
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 3; k++) pop_one("rnd");
            end
            if ($urandom_range(0, 7) == 0) begin
                clr_pulse();
                check_all("rnd.clr");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
